// File: rtl/idct_out_reorder.sv
`default_nettype none
//============================================================================
// idct_out_reorder : ping-pong frame buffer emitting x[2m]=v[m], x[2m+1]=v[N-1-m]
// Option: IDCT_REORDER_ERRCNT_EN adds err_cnt, a saturating frame_err counter.
// Rev 1.0
//============================================================================
module idct_out_reorder #(
  parameter int wData   = 24,
  parameter int MAX_PTS = 2048,
  parameter int wAddr   = 11
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic [wData-1:0] sink_real,
  input  logic [wData-1:0] sink_imag,
  input  logic [11:0]      fftpts_in,
  output logic             source_valid,
  input  logic             source_ready,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [wData-1:0] source_imag,
  output logic [1:0]       source_error,
  output logic [11:0]      fftpts_out,
  output logic             frame_err
`ifdef IDCT_REORDER_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam int NW = 12;
  localparam int DW = 2 * wData;
  localparam int EW = DW + NW + 2;
  localparam logic [NW-1:0]    MAX_CNT = NW'(MAX_PTS);
  localparam logic [NW-1:0]    N_ONE   = NW'(1);
  localparam logic [wAddr-1:0] A_ONE   = wAddr'(1);

  typedef enum logic { W_IDLE = 1'b0, W_FILL = 1'b1 } wstate_e;
  typedef enum logic { R_IDLE = 1'b0, R_RUN  = 1'b1 } rstate_e;

  logic [DW-1:0] mem [0:2*MAX_PTS-1];

  wstate_e           wstate_q, wstate_d;
  logic [NW-1:0]     wcnt_q, wcnt_d;
  logic [NW-1:0]     wn_q, wn_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        full_q, full_d;
  logic [1:0][NW-1:0] bank_n_q, bank_n_d;
  logic              ferr_q, ferr_d;

  rstate_e           rstate_q, rstate_d;
  logic [NW-1:0]     k_q, k_d;
  logic [NW-1:0]     len_q, len_d;
  logic              iss_bank_q, iss_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        done_q, done_d;
  logic              rvalid_q;
  logic [NW+1:0]     rmeta_q;
  logic [DW-1:0]     rdata_q;
  logic [EW-1:0]     ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              accept, we, set_full, ovf, done_set;
  logic [wAddr-1:0]  waddr, raddr, khalf;
  logic [NW-1:0]     wlen, set_n;
  logic              pop, pop_eop, issue, klast, room, nxt;
  logic [1:0]        occ;

  assign accept = sink_valid & sink_ready;
  assign ovf    = (wcnt_q >= MAX_CNT);
  assign wlen   = wcnt_q + N_ONE;

  // A sop always restarts the frame; a sop seen mid-frame is itself an error.
  always_comb begin
    wstate_d  = wstate_q;
    wcnt_d    = wcnt_q;
    wn_d      = wn_q;
    wr_bank_d = wr_bank_q;
    we        = 1'b0;
    waddr     = wcnt_q[wAddr-1:0];
    set_full  = 1'b0;
    set_n     = wn_q;
    ferr_d    = 1'b0;
    if (accept) begin
      if (sink_sop) begin
        we       = 1'b1;
        waddr    = '0;
        wn_d     = fftpts_in;
        set_n    = fftpts_in;
        wcnt_d   = N_ONE;
        wstate_d = W_FILL;
        if (wstate_q == W_FILL) ferr_d = 1'b1;
        if (sink_eop) begin
          wstate_d = W_IDLE;
          if (fftpts_in == N_ONE) set_full = 1'b1;
          else                    ferr_d   = 1'b1;
        end
      end else if (wstate_q == W_FILL) begin
        if (!ovf) begin
          we     = 1'b1;
          wcnt_d = wcnt_q + N_ONE;
        end
        if (sink_eop) begin
          wstate_d = W_IDLE;
          if (!ovf && (wlen == wn_q)) set_full = 1'b1;
          else                        ferr_d   = 1'b1;
        end
      end
    end
    if (set_full) wr_bank_d = ~wr_bank_q;
  end

  assign pop     = (cnt_q != 2'd0) & source_ready;
  assign pop_eop = pop & ent0_q[DW];
  assign occ     = cnt_q + {1'b0, rvalid_q};
  assign room    = (occ < 2'd2) | pop;
  assign issue   = (rstate_q == R_RUN) & room;
  assign klast   = (k_q == (len_q - N_ONE));
  assign khalf   = k_q[wAddr:1];
  assign raddr   = k_q[0] ? (len_q[wAddr-1:0] - A_ONE - khalf) : khalf;
  assign nxt     = ~iss_bank_q;

  // Issue side runs ahead of the output; done_q keeps a still-draining bank from being re-read.
  always_comb begin
    rstate_d   = rstate_q;
    k_d        = k_q;
    len_d      = len_q;
    iss_bank_d = iss_bank_q;
    done_set   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (full_q[iss_bank_q] && !done_q[iss_bank_q]) begin
          rstate_d = R_RUN;
          len_d    = bank_n_q[iss_bank_q];
          k_d      = '0;
        end
      end
      R_RUN: begin
        if (issue) begin
          if (klast) begin
            done_set   = 1'b1;
            iss_bank_d = nxt;
            if (full_q[nxt] && !done_q[nxt]) begin
              len_d = bank_n_q[nxt];
              k_d   = '0;
            end else begin
              rstate_d = R_IDLE;
            end
          end else begin
            k_d = k_q + N_ONE;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    full_d   = full_q;
    done_d   = done_q;
    bank_n_d = bank_n_q;
    if (set_full) begin
      full_d[wr_bank_q]   = 1'b1;
      bank_n_d[wr_bank_q] = set_n;
    end
    if (done_set) done_d[iss_bank_q] = 1'b1;
    if (pop_eop) begin
      full_d[rd_bank_q] = 1'b0;
      done_d[rd_bank_q] = 1'b0;
    end
  end

  assign rd_bank_d = rd_bank_q ^ pop_eop;

  // Two-entry skid; ent0 is only overwritten by real data so fftpts_out holds between frames.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({rvalid_q, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = {rmeta_q, rdata_q};
        else               ent1_d = {rmeta_q, rdata_q};
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) ent0_d = ent1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = {rmeta_q, rdata_q};
        end else begin
          ent0_d = {rmeta_q, rdata_q};
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we)    mem[{wr_bank_q, waddr}] <= {sink_real, sink_imag};
    if (issue) rdata_q <= mem[{iss_bank_q, raddr}];
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      wstate_q   <= W_IDLE;
      wcnt_q     <= '0;
      wn_q       <= '0;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      bank_n_q   <= '0;
      ferr_q     <= 1'b0;
      rstate_q   <= R_IDLE;
      k_q        <= '0;
      len_q      <= '0;
      iss_bank_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      done_q     <= '0;
      rvalid_q   <= 1'b0;
      rmeta_q    <= '0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      cnt_q      <= '0;
    end else begin
      wstate_q   <= wstate_d;
      wcnt_q     <= wcnt_d;
      wn_q       <= wn_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      bank_n_q   <= bank_n_d;
      ferr_q     <= ferr_d;
      rstate_q   <= rstate_d;
      k_q        <= k_d;
      len_q      <= len_d;
      iss_bank_q <= iss_bank_d;
      rd_bank_q  <= rd_bank_d;
      done_q     <= done_d;
      rvalid_q   <= issue;
      if (issue) rmeta_q <= {len_q, (k_q == '0), klast};
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sink_ready   = ~full_q[wr_bank_q];
  assign source_valid = (cnt_q != 2'd0);
  assign source_sop   = source_valid & ent0_q[DW+1];
  assign source_eop   = source_valid & ent0_q[DW];
  assign source_real  = ent0_q[DW-1:wData];
  assign source_imag  = ent0_q[wData-1:0];
  assign fftpts_out   = ent0_q[EW-1:DW+2];
  assign source_error = 2'b00;
  assign frame_err    = ferr_q;

`ifdef IDCT_REORDER_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync)                          err_cnt_q <= '0;
    else if (ferr_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire
